regfile_write_ctrl: RTL and testbench
=====================================

// Module: regfile_write_ctrl
// PURPOSE
//  Write-side controller for the register file. It accepts retiring results from the MEM
//  stage through a valid/ready handshake, formats load data and selects the writeback source.
//  It queues results in a DEPTH-entry FIFO and arbitrates the single regfile write port
//  between that FIFO and the multiply/divide unit (MDU).
//  It also supplies bypass data to the decode-stage readers for results not yet in the regfile.
// PARAMETERS
//  DEPTH  2  writeback FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  rst_n          in   1   asynchronous active-low reset
//  mem_valid      in   1   MEM stage presents a result
//  mem_ready      out  1   controller accepts the result this cycle
//  mem_regwrite   in   1   result writes a register
//  mem_rd         in   5   destination register
//  mem_wbsel      in   2   0=ALU, 1=load, 2=link (pc+4), 3=ALU
//  mem_alu_result in   32  ALU result
//  mem_load_data  in   32  raw 32-bit word read from data memory
//  mem_addr_lo    in   2   byte offset of the load address
//  mem_ldsize     in   2   0=byte, 1=half, 2/3=word
//  mem_ldsigned   in   1   sign-extend sub-word loads
//  mem_pc_plus4   in   32  link value
//  mdu_valid      in   1   MDU result pending
//  mdu_ready      out  1   MDU result is written this cycle
//  mdu_rd         in   5   MDU destination register
//  mdu_data       in   32  MDU result
//  RegWrite       out  1   regfile write enable
//  WriteRegister  out  5   regfile write address
//  WriteData      out  32  regfile write data
//  rs1_addr       in   5   decode read address 1
//  rs2_addr       in   5   decode read address 2
//  rs1_hit        out  1   bypass hit for rs1
//  rs2_hit        out  1   bypass hit for rs2
//  rs1_data       out  32  bypass data for rs1
//  rs2_data       out  32  bypass data for rs2
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, last_mdu=0.
//    All outputs are 0 while in reset, except mem_ready=1.
//  - mem_ready = (count<DEPTH); there is no same-cycle fall-through.
//    A push occurs on mem_valid&mem_ready at posedge.
//  - Pushed entry stores rd, we = mem_regwrite & (mem_rd!=0), and formatted data:
//    byte = load_data[8*addr_lo+:8]; half = load_data[16*addr_lo[1]+:16]; word = full 32 bits.
//    Sub-word values are sign-extended when ldsigned=1, otherwise zero-extended.
//    addr_lo[0] is ignored for half loads.
//  - Write-port grant each cycle:
//    - gnt_mdu = mdu_valid & !(full & last_mdu); mdu_ready = gnt_mdu.
//    - Otherwise, if the FIFO is non-empty, the head pops at posedge.
//    - last_mdu is registered as gnt_mdu, so when the FIFO is full, grants alternate.
//  - Write outputs are combinational from the grant:
//    - gnt_mdu: RegWrite = (mdu_rd!=0), address/data from the MDU.
//    - head pop: RegWrite = head.we, address/data from the head.
//    - otherwise all three outputs are 0.
//    - The regfile captures the write on the same posedge as the pop.
//  - A push and a pop may occur in the same cycle; count is unchanged.
//    Pointers wrap modulo DEPTH.
//  - Bypass: candidates are the granted MDU write (newest) and FIFO entries with we=1,
//    searched newest to oldest; the newest match wins.
//    rsX_hit=1 only when rsX_addr!=0 and a candidate matches. rsX_data=0 on a miss.
//  - Reset mid-operation drops all queued entries without writing them.
//    MEM must re-present its result after reset.
// TESTING
//  - Reset, then ALU push rd=5, data 0x1234_5678:
//    next cycle RegWrite=1, WriteRegister=5, WriteData=0x12345678; FIFO empty after.
//  - Load 0x80FF_7F01 with addr_lo=1, byte, signed -> 0x0000_007F;
//    addr_lo=3 -> 0xFFFF_FF80; half unsigned addr_lo=2 -> 0x0000_80FF.
//  - Push rd=0 with regwrite=1: the entry pops with RegWrite=0, and rs1_addr=0 gives rs1_hit=0.
//  - Hold mdu_valid=1 with mem_valid=1 every cycle:
//    mem_ready drops once the FIFO is full; grants then alternate MDU/FIFO and no entry is lost.
//  - Two queued writes to rd=9 (0xA, then 0xB): rs2_addr=9 gives rs2_data=0xB until the second pops.
//  - Assert rst_n=0 with 2 entries queued: RegWrite=0 immediately; mem_ready=1 after release.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Write-side controller: formats MEM results into a small writeback FIFO, arbitrates the
// single regfile write port between that FIFO and the MDU, and bypasses pending results.
module regfile_write_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wbsel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [1:0]  mem_addr_lo,
    input  logic [1:0]  mem_ldsize,
    input  logic        mem_ldsigned,
    input  logic [31:0] mem_pc_plus4,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_hit,
    output logic        rs2_hit,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t       fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;
    logic            last_mdu_q;

    logic            full, push, pop, gnt_mdu;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     load_fmt, wb_data;
    wb_entry_t       head, new_entry;
    logic [PW-1:0]   idx;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign mem_ready = (count_q < (PW+1)'(DEPTH));
    assign push      = mem_valid & mem_ready;
    // The grant is gated by rst_n so every write-side output reads 0 while reset is held.
    assign gnt_mdu   = rst_n & mdu_valid & ~(full & last_mdu_q);
    assign mdu_ready = gnt_mdu;
    assign pop       = rst_n & ~gnt_mdu & (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        ld_byte = mem_load_data[{mem_addr_lo, 3'b000} +: 8];
        ld_half = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        case (mem_ldsize)
            2'd0:    load_fmt = {{24{mem_ldsigned & ld_byte[7]}}, ld_byte};
            2'd1:    load_fmt = {{16{mem_ldsigned & ld_half[15]}}, ld_half};
            default: load_fmt = mem_load_data;
        endcase
        case (mem_wbsel)
            2'd1:    wb_data = load_fmt;
            2'd2:    wb_data = mem_pc_plus4;
            default: wb_data = mem_alu_result;
        endcase
        new_entry.we   = mem_regwrite & (mem_rd != 5'd0);
        new_entry.rd   = mem_rd;
        new_entry.data = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_mdu_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            last_mdu_q <= gnt_mdu;
            if (push) begin
                fifo_q[wr_ptr_q] <= new_entry;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        if (gnt_mdu) begin
            RegWrite      = (mdu_rd != 5'd0);
            WriteRegister = mdu_rd;
            WriteData     = mdu_data;
        end else if (pop) begin
            RegWrite      = head.we;
            WriteRegister = head.rd;
            WriteData     = head.data;
        end
    end

    // Scan oldest to newest so later matches overwrite earlier ones; the MDU write is newest.
    always_comb begin
        rs1_hit  = 1'b0;
        rs1_data = 32'd0;
        rs2_hit  = 1'b0;
        rs2_data = 32'd0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && fifo_q[idx].we) begin
                if (fifo_q[idx].rd == rs1_addr) begin
                    rs1_hit  = 1'b1;
                    rs1_data = fifo_q[idx].data;
                end
                if (fifo_q[idx].rd == rs2_addr) begin
                    rs2_hit  = 1'b1;
                    rs2_data = fifo_q[idx].data;
                end
            end
        end
        if (gnt_mdu && (mdu_rd == rs1_addr)) begin
            rs1_hit  = 1'b1;
            rs1_data = mdu_data;
        end
        if (gnt_mdu && (mdu_rd == rs2_addr)) begin
            rs2_hit  = 1'b1;
            rs2_data = mdu_data;
        end
        if (rs1_addr == 5'd0) begin
            rs1_hit  = 1'b0;
            rs1_data = 32'd0;
        end
        if (rs2_addr == 5'd0) begin
            rs2_hit  = 1'b0;
            rs2_data = 32'd0;
        end
    end
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed scenario tasks plus a cycle monitor that keeps a
// reference queue of pending writebacks and checks the write port and bypass every cycle.
module tb_regfile_write_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_ready, mem_regwrite = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [1:0]  mem_wbsel = '0, mem_addr_lo = '0, mem_ldsize = '0;
    logic [31:0] mem_alu_result = '0, mem_load_data = '0, mem_pc_plus4 = '0;
    logic        mem_ldsigned = 1'b0;
    logic        mdu_valid = 1'b0, mdu_ready;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic        rs1_hit, rs2_hit;
    logic [31:0] rs1_data, rs2_data;

    int n_cmp = 0;
    int n_err = 0;

    // {we, rd, data} of every accepted MEM result not yet written
    logic [37:0] exp_q[$];
    int          m_count = 0;
    logic        m_last = 1'b0;

    regfile_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_addr_lo(mem_addr_lo), .mem_ldsize(mem_ldsize),
        .mem_ldsigned(mem_ldsigned), .mem_pc_plus4(mem_pc_plus4),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmt_result(input logic [1:0] wbsel, input logic [31:0] alu,
                                               input logic [31:0] ld, input logic [1:0] lo,
                                               input logic [1:0] size, input logic sgn,
                                               input logic [31:0] pc);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] l;
        case (lo)
            2'd0:    b = ld[7:0];
            2'd1:    b = ld[15:8];
            2'd2:    b = ld[23:16];
            default: b = ld[31:24];
        endcase
        h = (lo >= 2'd2) ? ld[31:16] : ld[15:0];
        if (size == 2'd0)      l = (sgn && b[7])  ? {24'hFFFFFF, b} : {24'h0, b};
        else if (size == 2'd1) l = (sgn && h[15]) ? {16'hFFFF, h}   : {16'h0, h};
        else                   l = ld;
        if (wbsel == 2'd1)      return l;
        else if (wbsel == 2'd2) return pc;
        else                    return alu;
    endfunction

    // Reference model and scoreboard, evaluated once per cycle at the falling edge.
    always begin : monitor
        logic        m_gnt, m_push, m_pop, b1_hit, b2_hit;
        logic [31:0] b1_data, b2_data;
        logic [37:0] e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_count = 0;
            m_last  = 1'b0;
        end
        m_gnt = rst_n && mdu_valid && !((m_count == DEPTH) && m_last);
        n_cmp++;
        if (mdu_ready !== m_gnt) begin
            n_err++;
            $display("FAIL mdu_ready t=%0t: got %b expected %b", $time, mdu_ready, m_gnt);
        end
        n_cmp++;
        if (mem_ready !== (m_count < DEPTH)) begin
            n_err++;
            $display("FAIL mem_ready t=%0t: got %b expected %b", $time, mem_ready, m_count < DEPTH);
        end
        b1_hit = 1'b0; b1_data = '0; b2_hit = 1'b0; b2_data = '0;
        foreach (exp_q[k]) begin
            if (exp_q[k][37] && exp_q[k][36:32] == rs1_addr) begin b1_hit = 1'b1; b1_data = exp_q[k][31:0]; end
            if (exp_q[k][37] && exp_q[k][36:32] == rs2_addr) begin b2_hit = 1'b1; b2_data = exp_q[k][31:0]; end
        end
        if (m_gnt && mdu_rd == rs1_addr) begin b1_hit = 1'b1; b1_data = mdu_data; end
        if (m_gnt && mdu_rd == rs2_addr) begin b2_hit = 1'b1; b2_data = mdu_data; end
        if (rs1_addr == 5'd0) begin b1_hit = 1'b0; b1_data = '0; end
        if (rs2_addr == 5'd0) begin b2_hit = 1'b0; b2_data = '0; end
        n_cmp++;
        if ({rs1_hit, rs1_data, rs2_hit, rs2_data} !== {b1_hit, b1_data, b2_hit, b2_data}) begin
            n_err++;
            $display("FAIL bypass t=%0t: got rs1 %b/%h rs2 %b/%h expected rs1 %b/%h rs2 %b/%h",
                     $time, rs1_hit, rs1_data, rs2_hit, rs2_data, b1_hit, b1_data, b2_hit, b2_data);
        end
        m_pop = 1'b0;
        if (m_gnt) begin
            e = {mdu_rd != 5'd0, mdu_rd, mdu_data};
        end else if (m_count > 0) begin
            e = exp_q.pop_front();
            m_pop = 1'b1;
        end else begin
            e = '0;
        end
        n_cmp++;
        if ({RegWrite, WriteRegister, WriteData} !== e) begin
            n_err++;
            $display("FAIL write_port t=%0t: got we=%b rd=%0d data=%h expected we=%b rd=%0d data=%h",
                     $time, RegWrite, WriteRegister, WriteData, e[37], e[36:32], e[31:0]);
        end
        m_push = rst_n && mem_valid && (m_count < DEPTH);
        if (m_push)
            exp_q.push_back({mem_regwrite && (mem_rd != 5'd0), mem_rd,
                             fmt_result(mem_wbsel, mem_alu_result, mem_load_data, mem_addr_lo,
                                        mem_ldsize, mem_ldsigned, mem_pc_plus4)});
        @(posedge clk);
        if (rst_n) begin
            m_count = m_count + int'(m_push) - int'(m_pop);
            m_last  = m_gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [1:0] wbsel,
                             input logic [31:0] alu);
        mem_valid      = v;
        mem_regwrite   = 1'b1;
        mem_rd         = rd;
        mem_wbsel      = wbsel;
        mem_alu_result = alu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hCAFE_0003;
        drive_mem(1'b1, 5'd3, 2'd0, 32'h1);
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        tick(); tick(); #2;
        n_cmp++;
        if ({mem_ready, mdu_ready, RegWrite, WriteRegister, WriteData} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b mdu_rdy=%b we=%b rd=%0d data=%h expected 1 0 0 0 0",
                     mem_ready, mdu_ready, RegWrite, WriteRegister, WriteData);
        end
        n_cmp++;
        if ({rs1_hit, rs2_hit, rs1_data, rs2_data} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_bypass: got %b %b %h %h expected all 0", rs1_hit, rs2_hit, rs1_data, rs2_data);
        end
        mdu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_alu_push();
        tick();
        drive_mem(1'b1, 5'd5, 2'd0, 32'h1234_5678);
        rs1_addr = 5'd5;
        tick();
        mem_valid = 1'b0;
        #2;
        n_cmp++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL alu_write: got %b %0d %h expected 1 5 12345678", RegWrite, WriteRegister, WriteData);
        end
        n_cmp++;
        if ({rs1_hit, rs1_data} !== {1'b1, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL alu_bypass: got %b %h expected 1 12345678", rs1_hit, rs1_data);
        end
        tick(); #2;
        n_cmp++;
        if ({mem_ready, RegWrite, rs1_hit} !== 3'b100) begin
            n_err++;
            $display("FAIL alu_empty_after: got rdy=%b we=%b hit=%b expected 1 0 0", mem_ready, RegWrite, rs1_hit);
        end
        rs1_addr = 5'd0;
    endtask

    task automatic test_load_format();
        logic [1:0]  lo_t  [3] = '{2'd1, 2'd3, 2'd2};
        logic [1:0]  sz_t  [3] = '{2'd0, 2'd0, 2'd1};
        logic        sg_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exp_t [3] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF};
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_mem(1'b1, 5'd7, 2'd1, 32'h0);
            mem_load_data = 32'h80FF_7F01;
            mem_addr_lo   = lo_t[i];
            mem_ldsize    = sz_t[i];
            mem_ldsigned  = sg_t[i];
            tick();
            mem_valid = 1'b0;
            #2;
            n_cmp++;
            if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd7, exp_t[i]}) begin
                n_err++;
                $display("FAIL load_fmt[%0d]: got %b %0d %h expected 1 7 %h", i, RegWrite, WriteRegister, WriteData, exp_t[i]);
            end
        end
        tick();
    endtask

    task automatic test_rd_zero();
        tick();
        drive_mem(1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF);
        rs1_addr = 5'd0;
        tick();
        mem_valid = 1'b0;
        #2;
        n_cmp++;
        if ({RegWrite, rs1_hit} !== 2'b00) begin
            n_err++;
            $display("FAIL rd_zero: got we=%b hit=%b expected 0 0", RegWrite, rs1_hit);
        end
        tick();
    endtask

    task automatic test_contention();
        logic prev_mdu = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            drive_mem(1'b1, 5'($urandom_range(1, 31)), 2'd0, $urandom);
            mdu_valid = 1'b1;
            mdu_rd    = 5'($urandom_range(1, 31));
            mdu_data  = $urandom;
            #2;
            n_cmp++;
            if (mem_ready !== ((i >= 2 && i % 2 == 0) ? 1'b0 : 1'b1)) begin
                n_err++;
                $display("FAIL contention_ready[%0d]: got %b", i, mem_ready);
            end
            if (i >= 2) begin
                n_cmp++;
                if (mdu_ready === prev_mdu) begin
                    n_err++;
                    $display("FAIL contention_alternate[%0d]: got mdu_ready=%b expected %b", i, mdu_ready, !prev_mdu);
                end
            end
            prev_mdu = mdu_ready;
        end
        tick();
        mem_valid = 1'b0; mdu_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_same_rd();
        tick();
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h3333;
        drive_mem(1'b1, 5'd9, 2'd0, 32'hA);
        rs2_addr = 5'd9;
        tick();
        mem_alu_result = 32'hB;
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) mdu_valid = 1'b0;
            #2;
            n_cmp++;
            if ({rs2_hit, rs2_data} !== ((i < 3) ? {1'b1, 32'hB} : {1'b0, 32'h0})) begin
                n_err++;
                $display("FAIL same_rd[%0d]: got %b %h", i, rs2_hit, rs2_data);
            end
            tick();
        end
        rs2_addr = 5'd0;
    endtask

    task automatic test_reset_mid();
        tick();
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h77;
        drive_mem(1'b1, 5'd10, 2'd0, 32'h10);
        rs1_addr = 5'd10;
        tick();
        mem_rd = 5'd11;
        tick();
        mem_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_full: got mem_ready=%b expected 0", mem_ready);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({RegWrite, mdu_ready, mem_ready, rs1_hit} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_mid_now: got we=%b mdu_rdy=%b rdy=%b hit=%b expected 0 0 1 0",
                     RegWrite, mdu_ready, mem_ready, rs1_hit);
        end
        tick();
        mdu_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++;
            if ({mem_ready, RegWrite} !== 2'b10) begin
                n_err++;
                $display("FAIL reset_mid_after[%0d]: got rdy=%b we=%b expected 1 0", i, mem_ready, RegWrite);
            end
            tick();
        end
        rs1_addr = 5'd0;
    endtask

    task automatic test_random();
        logic acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!(mem_valid && !acc)) begin
                mem_valid      = ($urandom_range(0, 2) != 0);
                mem_regwrite   = ($urandom_range(0, 4) != 0);
                mem_rd         = 5'($urandom_range(0, 7));
                mem_wbsel      = 2'($urandom_range(0, 3));
                mem_alu_result = $urandom;
                mem_load_data  = $urandom;
                mem_addr_lo    = 2'($urandom_range(0, 3));
                mem_ldsize     = 2'($urandom_range(0, 3));
                mem_ldsigned   = 1'($urandom_range(0, 1));
                mem_pc_plus4   = $urandom;
            end
            mdu_valid = ($urandom_range(0, 2) == 0);
            mdu_rd    = 5'($urandom_range(0, 7));
            mdu_data  = $urandom;
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            #2;
            acc = mem_valid && mem_ready;
        end
        tick();
        mem_valid = 1'b0; mdu_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_alu_push();
        test_load_format();
        test_rd_zero();
        test_contention();
        test_same_rd();
        test_reset_mid();
        test_random();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
